// File: rtl/dbus_sram_responder.sv
// Single-outstanding data-bus SRAM responder: fixed-latency reads and byte-strobed writes.
// Optional misalignment rejection is enabled by defining DBUS_ALIGN_CHECK_EN.
package dbus_pkg;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       err
);
    localparam int unsigned AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

`ifdef DBUS_ALIGN_CHECK_EN
    localparam logic ALIGN_CHECK = 1'b1;
`else
    localparam logic ALIGN_CHECK = 1'b0;
`endif

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic [7:0]    r_strobe;
    logic [63:0]   r_wdata;
    logic          r_reject;

    logic [63:0]   w_offset;
    logic [AW-1:0] w_idx;
    logic          w_in_range;
    logic          w_misaligned;
    logic          w_reject;
    logic          w_accept;
    logic          w_data_ok;
    logic          w_we;
    logic [63:0]   w_rdata;

    // Offset is only meaningful when addr >= BASE_ADDR; low three bits never select a word.
    assign w_offset   = dreq.addr - BASE_ADDR;
    assign w_idx      = w_offset[AW+2:3];
    assign w_in_range = (dreq.addr >= BASE_ADDR) && (w_offset < SPAN);

    always_comb begin
        w_misaligned = 1'b0;
        case (dreq.size)
            MSIZE2:  w_misaligned = dreq.addr[0];
            MSIZE4:  w_misaligned = |dreq.addr[1:0];
            MSIZE8:  w_misaligned = |dreq.addr[2:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_reject  = !w_in_range || (ALIGN_CHECK && w_misaligned);
    // Reset gates the combinational handshakes so they read 0 while reset is held.
    assign w_accept  = reset && (r_state == IDLE) && dreq.valid;
    assign w_data_ok = reset && (r_state == RESP) && dreq.valid;
    assign w_we      = w_data_ok && !r_reject && (r_strobe != 8'h00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_idx    <= '0;
            r_strobe <= 8'h00;
            r_wdata  <= 64'd0;
            r_reject <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dreq.valid) begin
                        r_idx    <= w_idx;
                        r_strobe <= dreq.strobe;
                        r_wdata  <= dreq.data;
                        r_reject <= w_reject;
                        if (LATENCY == 1) begin
                            r_state <= RESP;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (!dreq.valid) begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // One RAM per byte lane. The read is taken at accept; no write can land before RESP,
    // so the RESP data is the pre-write word.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_rd;

        always_ff @(posedge clk) begin
            if (w_we && r_strobe[gi]) begin
                r_mem[r_idx] <= r_wdata[gi*8 +: 8];
            end
            if (w_accept) begin
                r_rd <= r_mem[w_idx];
            end
        end

        assign w_rdata[gi*8 +: 8] = r_rd;
    end

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = w_accept;
        dresp.data_ok = w_data_ok;
        if (w_data_ok && !r_reject) begin
            dresp.data = w_rdata;
        end
    end

    assign err = w_data_ok && r_reject;

endmodule

// File: doc/dbus_sram_responder.md
DBUS_SRAM_RESPONDER -- requirements
Module: dbus_sram_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 64-bit storage words (power of two).
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request accept to data_ok (legal range 1..15).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port dreq  input  dbus_req_t  request from memory stage (valid, addr, size, strobe, data).
REQ-007 SHALL have port dresp  output  dbus_resp_t  response (addr_ok, data_ok, data).
REQ-008 SHALL have port err  output  1  one-cycle pulse with data_ok when the completed request was rejected.

Function
REQ-009 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-010 SHALL, in IDLE with dreq.valid=1, accept: latch addr, size, strobe, data; assert dresp.addr_ok combinationally that cycle; go to RESP if LATENCY=1, else WAIT with cnt=LATENCY-1.
REQ-011 SHALL, in WAIT, go to RESP when cnt=1, else decrement cnt; data_ok therefore appears exactly LATENCY cycles after accept.
REQ-012 SHALL assert dresp.data_ok for exactly one cycle, in RESP, then return to IDLE; a new request is accepted no earlier than the following IDLE cycle.
REQ-013 SHALL drive dresp.data in RESP with the full 64-bit word at index (latched addr - BASE_ADDR)>>3, unshifted; byte selection is the initiator's job; data SHALL be 0 outside RESP.
REQ-014 SHALL, for a write (latched strobe != 0), update only bytes whose strobe bit is 1 at the clock edge ending RESP; RESP read data reflects pre-write contents.
REQ-015 SHALL, if dreq.valid drops during WAIT or RESP, abort to IDLE next cycle: no data_ok, no write, no err.
REQ-016 SHALL treat an address outside [BASE_ADDR, BASE_ADDR+8*DEPTH_WORDS) as rejected: completes with normal latency, data 0, no write, err=1 in RESP.
REQ-017 SHALL ignore changes to dreq fields other than valid after accept (latched values are used).
REQ-018 SHALL keep addr_ok=0 in WAIT and RESP.

Reset
REQ-019 SHALL, on reset low, asynchronously force state IDLE, cnt=0, addr_ok/data_ok/err=0, data=0.
REQ-020 SHALL, on reset during WAIT or RESP, discard the pending request; no storage byte is written.
REQ-021 SHALL not initialise storage contents on reset.

Configuration
REQ-022 SHALL, with DBUS_ALIGN_CHECK_EN defined, reject a request whose addr is not aligned to its size (MSIZE2: addr[0]!=0; MSIZE4: addr[1:0]!=0; MSIZE8: addr[2:0]!=0) exactly as REQ-016.
REQ-023 SHALL, without DBUS_ALIGN_CHECK_EN, ignore addr[2:0] for indexing and apply strobe as given, never asserting err for alignment.

Verification
REQ-024 SHALL cover: LATENCY=2, read addr 8000_0010 after reset -> addr_ok at T, data_ok only at T+2, err=0.
REQ-025 SHALL cover: write 8000_0008 data 1122334455667788 strobe 8'h0F, then read same -> data low 32 bits 55667788, upper bytes unchanged.
REQ-026 SHALL cover: read addr 0000_1000 -> data_ok at T+LATENCY, data 0, err=1, storage unchanged.
REQ-027 SHALL cover: write accepted, valid dropped at T+1 (LATENCY=3) -> no data_ok, subsequent read shows old word.
REQ-028 SHALL cover: reset asserted in WAIT of a write -> outputs 0 immediately, word unchanged after release.
REQ-029 SHALL cover: DBUS_ALIGN_CHECK_EN defined, MSIZE4 read at 8000_0002 -> err=1, data 0; undefined -> err=0, word at 8000_0000 returned.
